// File: rtl/pcs_tx_enc.sv
// pcs_tx_enc: packs BEAT_N MAC beats into one 64-bit block, classifies it
// (data / start / terminate / idle / error) and emits a 66-bit block with
// sync header in bits [1:0]. Gearbox backpressure stalls the beat stream.
module pcs_tx_enc #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int BLOCK_W     = 64,
  parameter int BEAT_N      = BLOCK_W / DATA_W,
  parameter int BLOCK_LEN_W = 4,
  parameter int BEAT_CNT_W  = (BEAT_N > 1) ? $clog2(BEAT_N) : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   ctrl_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   start_i,
  input  logic                   idle_i,
  input  logic                   term_i,
  input  logic [BLOCK_LEN_W-1:0] term_len_i,
  output logic                   ready_o,
  output logic                   block_v_o,
  output logic [65:0]            block_o,
  input  logic                   block_ready_i,
  output logic                   err_o
);

  logic [BEAT_CNT_W-1:0]  cnt_q;
  logic [BLOCK_W-1:0]     blk_q;
  logic [BLOCK_W-1:0]     blk_cur;
  logic                   start_q, misplaced_q, nocv_q, term_q, all_idle_q, any_idle_q;
  logic                   start_a, misplaced_a, nocv_a, term_a, all_idle_a, any_idle_a;
  logic [BLOCK_LEN_W-1:0] tlen_q, tlen_a;
  logic                   first_beat, last_beat, accept, load;
  logic                   is_err;
  logic [63:0]            payload;
  logic [1:0]             sync;
  logic                   block_v_q, err_q;
  logic [65:0]            block_q;

  function automatic logic [7:0] term_type(input logic [2:0] n);
    case (n)
      3'd0:    term_type = 8'h87;
      3'd1:    term_type = 8'h99;
      3'd2:    term_type = 8'hAA;
      3'd3:    term_type = 8'hB4;
      3'd4:    term_type = 8'hCC;
      3'd5:    term_type = 8'hD2;
      3'd6:    term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
  endfunction

  assign ready_o    = ~block_v_q | block_ready_i;
  assign accept     = ready_o;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == BEAT_CNT_W'(BEAT_N - 1));
  assign load       = accept & last_beat;

  // Merge the current beat into the partial block and its flags; on the
  // last beat these merged values are what gets classified.
  always_comb begin
    blk_cur = blk_q;
    for (int k = 0; k < BEAT_N; k++) begin
      if (cnt_q == BEAT_CNT_W'(k)) blk_cur[k*KEEP_W*8 +: KEEP_W*8] = data_i;
    end
    start_a     = start_q | (start_i & ctrl_v_i & first_beat);
    misplaced_a = misplaced_q | (start_i & ~first_beat);
    nocv_a      = nocv_q | (start_i & ~ctrl_v_i);
    term_a      = term_q | term_i;
    all_idle_a  = all_idle_q & idle_i;
    any_idle_a  = any_idle_q | idle_i;
    tlen_a      = (term_i & ~term_q) ? term_len_i : tlen_q;
  end

  // Classify the completed block (error has top priority) and build payload.
  always_comb begin
    is_err  = misplaced_a | (start_a & term_a) | (tlen_a > BLOCK_LEN_W'(7)) | nocv_a
            | (any_idle_a & ~all_idle_a & ~term_a);
    payload = blk_cur;
    sync    = 2'b01;
    if (is_err) begin
      payload = {{8{7'h1E}}, 8'h1E};
      sync    = 2'b10;
    end else if (all_idle_a) begin
      payload = {56'h0, 8'h1E};
      sync    = 2'b10;
    end else if (start_a) begin
      payload = {blk_cur[63:8], 8'h78};
      sync    = 2'b10;
    end else if (term_a) begin
      payload      = '0;
      payload[7:0] = term_type(tlen_a[2:0]);
      for (int i = 1; i < 8; i++) begin
        if (i <= int'(tlen_a[2:0])) payload[i*8 +: 8] = blk_cur[(i-1)*8 +: 8];
      end
      sync = 2'b10;
    end
  end

  // Beat counter and per-block accumulators; frozen while ready_o is low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q       <= '0;
      blk_q       <= '0;
      start_q     <= 1'b0;
      misplaced_q <= 1'b0;
      nocv_q      <= 1'b0;
      term_q      <= 1'b0;
      all_idle_q  <= 1'b1;
      any_idle_q  <= 1'b0;
      tlen_q      <= '0;
    end else if (accept) begin
      blk_q <= blk_cur;
      if (last_beat) begin
        cnt_q       <= '0;
        start_q     <= 1'b0;
        misplaced_q <= 1'b0;
        nocv_q      <= 1'b0;
        term_q      <= 1'b0;
        all_idle_q  <= 1'b1;
        any_idle_q  <= 1'b0;
        tlen_q      <= '0;
      end else begin
        cnt_q       <= cnt_q + BEAT_CNT_W'(1);
        start_q     <= start_a;
        misplaced_q <= misplaced_a;
        nocv_q      <= nocv_a;
        term_q      <= term_a;
        all_idle_q  <= all_idle_a;
        any_idle_q  <= any_idle_a;
        tlen_q      <= tlen_a;
      end
    end
  end

  // Output register: a load on the last beat may replace a block being taken
  // the same edge; err pulses only on the first cycle a block is presented.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      block_v_q <= 1'b0;
      block_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= load & is_err;
      if (load) begin
        block_v_q <= 1'b1;
        block_q   <= {payload, sync};
      end else if (block_ready_i) begin
        block_v_q <= 1'b0;
      end
    end
  end

  assign block_v_o = block_v_q;
  assign block_o   = block_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_pcs_tx_enc.sv
// Self-checking bench for pcs_tx_enc (DATA_W=16, four beats per block).
module tb_pcs_tx_enc;

  logic        clk = 1'b0;
  logic        nreset, ctrl_v_i, start_i, idle_i, term_i;
  logic [15:0] data_i;
  logic [3:0]  term_len_i;
  logic        ready_o, block_v_o, block_ready_i, err_o;
  logic [65:0] block_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [65:0] blk;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_d [4];
  logic        m_cv[4], m_st[4], m_id[4], m_tm[4];
  logic [3:0]  m_tl[4];
  int          m_pos = 0;

  logic mon_pv = 1'b0, mon_pt = 1'b0, mon_first;

  localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b10};
  localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b10};

  always #5 clk = ~clk;

  pcs_tx_enc #(.DATA_W(16)) dut (
    .clk(clk), .nreset(nreset), .ctrl_v_i(ctrl_v_i), .data_i(data_i),
    .start_i(start_i), .idle_i(idle_i), .term_i(term_i), .term_len_i(term_len_i),
    .ready_o(ready_o), .block_v_o(block_v_o), .block_o(block_o),
    .block_ready_i(block_ready_i), .err_o(err_o)
  );

  // Reference: classify and encode the four stored beats of one block.
  function automatic exp_t model_block();
    exp_t       e;
    logic [7:0] b[8];
    logic [7:0] p[8];
    logic [7:0] ttab[8];
    logic       mis, nocv, anyt, alli, anyi, st_ok;
    logic [3:0] tl;
    logic [1:0] sy;
    ttab = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    mis = 0; nocv = 0; anyt = 0; alli = 1; anyi = 0; tl = 0;
    for (int k = 0; k < 4; k++) begin
      b[2*k]   = m_d[k][7:0];
      b[2*k+1] = m_d[k][15:8];
      if (m_st[k] && k != 0) mis = 1;
      if (m_st[k] && !m_cv[k]) nocv = 1;
      if (m_tm[k] && !anyt) tl = m_tl[k];
      anyt = anyt | m_tm[k];
      alli = alli & m_id[k];
      anyi = anyi | m_id[k];
    end
    st_ok = m_st[0] & m_cv[0];
    for (int i = 0; i < 8; i++) p[i] = 8'h00;
    sy = 2'b10;
    e.err = 1'b0;
    if (mis || (st_ok && anyt) || tl > 4'd7 || nocv || (anyi && !alli && !anyt)) begin
      e.err = 1'b1;
      e.blk = ERR_BLK;
      return e;
    end
    if (alli) begin
      p[0] = 8'h1E;
    end else if (st_ok) begin
      p = b;
      p[0] = 8'h78;
    end else if (anyt) begin
      p[0] = ttab[tl[2:0]];
      for (int i = 1; i <= int'(tl); i++) p[i] = b[i-1];
    end else begin
      p = b;
      sy = 2'b01;
    end
    e.blk = {p[7], p[6], p[5], p[4], p[3], p[2], p[1], p[0], sy};
    return e;
  endfunction

  // Drive one beat, wait (bounded) until accepted, record it in the model.
  task automatic send_beat(input logic [15:0] d, input logic cv, input logic st,
                           input logic id, input logic tm, input logic [3:0] tl);
    int guard;
    data_i = d; ctrl_v_i = cv; start_i = st; idle_i = id; term_i = tm; term_len_i = tl;
    #1;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: ready_o=%b, required 1 within %0d cycles", ready_o, guard);
    end else begin
      m_d[m_pos] = d; m_cv[m_pos] = cv; m_st[m_pos] = st;
      m_id[m_pos] = id; m_tm[m_pos] = tm; m_tl[m_pos] = tl;
      if (m_pos == 3) begin
        sb.push_back(model_block());
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    @(negedge clk);
  endtask

  // kind: 0 data, 1 start, 2 terminate, 3 idle
  task automatic send_block(input logic [63:0] d, input int kind, input logic [3:0] tl);
    for (int k = 0; k < 4; k++) begin
      case (kind)
        1:       send_beat(d[k*16 +: 16], k == 0, k == 0, 1'b0, 1'b0, 4'd0);
        2:       send_beat(d[k*16 +: 16], 1'b1, 1'b0, 1'b0, 1'b1, tl);
        3:       send_beat(d[k*16 +: 16], 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        default: send_beat(d[k*16 +: 16], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      endcase
    end
  endtask

  // Scoreboard monitor: compare each presented block, pop when taken.
  always @(negedge clk) begin
    #1;
    if (block_v_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: block_o=%h presented, none expected", block_o);
      end else begin
        mon_first = !mon_pv || mon_pt;
        checks++;
        if (block_o !== sb[0].blk) begin
          errors++;
          $display("FAIL sb_block: block_o=%h, required %h", block_o, sb[0].blk);
        end
        checks++;
        if (err_o !== (mon_first & sb[0].err)) begin
          errors++;
          $display("FAIL sb_err: err_o=%b, required %b", err_o, mon_first & sb[0].err);
        end
        if (block_ready_i === 1'b1) void'(sb.pop_front());
      end
    end else begin
      checks++;
      if (err_o !== 1'b0) begin
        errors++;
        $display("FAIL err_idle: err_o=%b with no block, required 0", err_o);
      end
    end
    mon_pv = block_v_o;
    mon_pt = block_v_o & block_ready_i;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (block_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: block_v_o=%b, required 0", block_v_o); end
    checks++; if (block_o !== 66'h0) begin errors++; $display("FAIL reset_block: block_o=%h, required 0", block_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: err_o=%b, required 0", err_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: ready_o=%b, required 1", ready_o); end
    nreset = 1'b1;
    block_ready_i = 1'b1;
  endtask

  task automatic test_idle();
    send_block(64'h0, 3, 4'd0);
    #1;
    checks++; if (block_v_o !== 1'b1) begin errors++; $display("FAIL idle_latency: block_v_o=%b, required 1", block_v_o); end
    checks++; if (block_o !== IDLE_BLK) begin errors++; $display("FAIL idle_block: block_o=%h, required %h", block_o, IDLE_BLK); end
  endtask

  task automatic test_start();
    send_block(64'hD555_5555_5555_55FB, 1, 4'd0);
    #1;
    checks++;
    if (block_o !== {64'hD555_5555_5555_5578, 2'b10}) begin
      errors++; $display("FAIL start_block: block_o=%h, required %h", block_o, {64'hD555_5555_5555_5578, 2'b10});
    end
  endtask

  task automatic test_term();
    send_block(64'h3344_1122_DDCC_BBAA, 2, 4'd3);
    #1;
    checks++;
    if (block_o !== {64'h0000_0000_CCBB_AAB4, 2'b10}) begin
      errors++; $display("FAIL term3_block: block_o=%h, required %h", block_o, {64'h0000_0000_CCBB_AAB4, 2'b10});
    end
    send_block(64'h1234_5678_9ABC_DEF0, 2, 4'd0);
    #1;
    checks++;
    if (block_o !== {64'h87, 2'b10}) begin
      errors++; $display("FAIL term0_block: block_o=%h, required %h", block_o, {64'h87, 2'b10});
    end
    send_block(64'h8877_6655_4433_2211, 2, 4'd7);
  endtask

  task automatic test_data();
    send_block(64'h0123_4567_89AB_CDEF, 0, 4'd0);
    #1;
    checks++;
    if (block_o !== {64'h0123_4567_89AB_CDEF, 2'b01}) begin
      errors++; $display("FAIL data_block: block_o=%h, required %h", block_o, {64'h0123_4567_89AB_CDEF, 2'b01});
    end
  endtask

  task automatic test_frame();
    send_block(64'hD555_5555_5555_55FB, 1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      send_block({$urandom, $urandom}, 0, 4'd0);
      #1;
      checks++;
      if (block_v_o !== 1'b1) begin errors++; $display("FAIL frame_gap: block_v_o=%b after block %0d, required 1", block_v_o, i); end
    end
    send_block({$urandom, $urandom}, 2, 4'd4);
  endtask

  task automatic test_stall();
    logic [63:0] a;
    a = {$urandom, $urandom};
    send_beat(a[15:0], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(a[31:16], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(a[47:32], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    block_ready_i = 1'b0;
    send_beat(a[63:48], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    fork
      send_block({$urandom, $urandom}, 0, 4'd0);
      begin
        repeat (5) begin
          @(negedge clk); #2;
          checks++;
          if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: ready_o=%b, required 0", ready_o); end
          checks++;
          if (block_o !== {a, 2'b01}) begin errors++; $display("FAIL stall_hold: block_o=%h, required %h", block_o, {a, 2'b01}); end
        end
        @(negedge clk);
        block_ready_i = 1'b1;
      end
    join
    send_block(64'hCAFE_F00D_1357_2468, 0, 4'd0);
  endtask

  task automatic test_error();
    send_beat(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(16'h3333, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    send_beat(16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    checks++; if (block_o !== ERR_BLK) begin errors++; $display("FAIL err_misplaced_block: block_o=%h, required %h", block_o, ERR_BLK); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_pulse: err_o=%b, required 1", err_o); end
    send_beat(16'h0A0B, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_end: err_o=%b, required 0", err_o); end
    send_beat(16'h0C0D, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    send_beat(16'h0E0F, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    send_beat(16'h1010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    #1;
    checks++; if (block_o !== ERR_BLK) begin errors++; $display("FAIL err_termlen_block: block_o=%h, required %h", block_o, ERR_BLK); end
    send_beat(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    send_beat(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    send_beat(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(16'h55FB, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    send_block(64'h0, 0, 4'd0);
  endtask

  task automatic test_reset_mid();
    send_beat(16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_beat(16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    block_ready_i = 1'b0;
    nreset = 1'b0;
    m_pos = 0;
    #1;
    checks++; if (block_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_v: block_v_o=%b, required 0", block_v_o); end
    checks++; if (block_o !== 66'h0) begin errors++; $display("FAIL rstmid_block: block_o=%h, required 0", block_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: ready_o=%b, required 1", ready_o); end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    block_ready_i = 1'b1;
    send_block(64'hFEDC_BA98_7654_3210, 0, 4'd0);
    #1;
    checks++;
    if (block_o !== {64'hFEDC_BA98_7654_3210, 2'b01}) begin
      errors++; $display("FAIL rstmid_align: block_o=%h, required %h", block_o, {64'hFEDC_BA98_7654_3210, 2'b01});
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      if (kind == 4) begin
        for (int k = 0; k < 4; k++) begin
          send_beat(16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                    ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 9)));
        end
      end else begin
        send_block({$urandom, $urandom}, kind, 4'($urandom_range(0, 7)));
      end
    end
    #2;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d blocks outstanding, required 0", sb.size()); end
  endtask

  initial begin
    nreset = 1'b0; block_ready_i = 1'b0;
    data_i = '0; ctrl_v_i = 0; start_i = 0; idle_i = 0; term_i = 0; term_len_i = '0;
    test_reset();
    test_idle();
    test_start();
    test_term();
    test_data();
    test_frame();
    test_stall();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
